dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It serves the MEM-stage load/store requests issued by the pipelined CPU (MemRead_i/MemWrite_i, addr_i, data_i).
- It replaces the single-cycle data memory. While an access is in flight, it raises stall_o so the pipeline freezes.
- It returns read data with a one-cycle ready_o pulse, and flags misaligned accesses.

---
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Freezes the pipeline while an access is in flight.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic [AW-1:0] idx;
  logic          mis;
  logic          unused_addr;

  assign req = MemRead_i | MemWrite_i;
  assign idx = addr_q[AW+1:2];
  assign mis = addr_q[1:0] != 2'b00;
  assign unused_addr = ^addr_i[31:AW+2];

  // Same-cycle freeze on detect; never stall while held in reset.
  assign stall_o = rst_n &
    (((state == IDLE) & req) | (state == BUSY));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      data_o  <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q <= addr_i[AW+1:0];
            data_q <= data_i;
            wr_q   <= MemWrite_i;
            cnt    <= CW'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state   <= DONE;
            ready_o <= 1'b1;
            if (mis) begin
              data_o <= '0;
              err_o  <= 1'b1;
            end else if (wr_q) begin
              mem[idx] <= data_q;
              data_o   <= data_q;
            end else begin
              data_o <= mem[idx];
            end
          end
        end
        DONE: begin
          // Request lines still belong to the finished access.
          state   <= IDLE;
          ready_o <= 1'b0;
          err_o   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Directed accesses push expectations; a monitor pops on ready_o.
module tb_dmem_responder;

  logic        clk_i;
  logic        rst_n;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        stall_o;
  logic        err_o;

  int checks;
  int errors;

  logic [32:0] exp_q [$];

  dmem_responder #(
    .DEPTH_WORDS(128),
    .LATENCY(2)
  ) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .addr_i(addr_i),
    .data_i(data_i),
    .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i),
    .data_o(data_o),
    .ready_o(ready_o),
    .stall_o(stall_o),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_n && ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready data %h err %b",
                 data_o, err_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_data", data_o, e[31:0]);
        chk("resp_err", {31'b0, err_o}, {31'b0, e[32]});
      end
    end
  end

  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] ed,
                        input bit ee,
                        input bit chg);
    int st;
    bit seen;
    @(negedge clk_i);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    data_i     = d;
    exp_q.push_back({ee, ed});
    st   = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clk_i);
      #1;
      if (ready_o) seen = 1;
      else if (stall_o) st++;
      if (chg && i == 1) begin
        addr_i     = a ^ 32'h0000_0040;
        data_i     = ~d;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
      end
    end
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    chk("ready_seen", {31'b0, seen}, 32'd1);
    chk("stall_cycles", st, 32'd3);
    @(negedge clk_i);
    #1;
    chk("ready_pulse_end", {31'b0, ready_o}, 32'd0);
    chk("idle_stall", {31'b0, stall_o}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b1;
    addr_i     = 32'h10;
    data_i     = 32'h1;
    #12;
    chk("rst_data", data_o, 32'h0);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;

    access(0, 1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h210, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(0, 1, 32'h13, 32'h5555_5555, 32'h0, 1, 0);
    access(1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(1, 1, 32'h20, 32'h1234_5678, 32'h1234_5678, 0, 0);
    access(1, 0, 32'h20, 32'h0, 32'h1234_5678, 0, 0);
    access(1, 0, 32'h24, 32'h0, 32'h0, 0, 0);
    access(1, 0, 32'h22, 32'h0, 32'h0, 1, 0);
    access(0, 1, 32'h40, 32'hAAAA_0001, 32'hAAAA_0001, 0, 1);
    access(1, 0, 32'h40, 32'h0, 32'hAAAA_0001, 0, 0);
    access(1, 0, 32'h00, 32'h0, 32'h0, 0, 0);

    // Reset while a write is in flight.
    @(negedge clk_i);
    MemWrite_i = 1'b1;
    addr_i     = 32'h30;
    data_i     = 32'hCAFE_0000;
    @(negedge clk_i);
    #1;
    chk("busy_stall", {31'b0, stall_o}, 32'd1);
    access_reset();

    access(1, 0, 32'h30, 32'h0, 32'h0, 0, 0);
    access(1, 0, 32'h10, 32'h0, 32'h0, 0, 0);

    repeat (3) @(negedge clk_i);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic access_reset();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_o, 32'h0);
    chk("mid_rst_ready", {31'b0, ready_o}, 32'd0);
    chk("mid_rst_err", {31'b0, err_o}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_o}, 32'd0);
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

endmodule
